// File: rtl/vec_pkg.sv
// Shared types for the vector-ALU result skid buffer: lane vector, FSM states, writeback payload.
package vec_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int LANES      = 6;
  localparam int REG_ADDR_W = 4;

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    lane_vec_t             result;
    logic [LANES-1:0]      cmp;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
  } vec_wb_payload_t;

endpackage

// File: rtl/vec_alu_result_skid_if.sv
// Valid/ready writeback channel carrying one vec_wb_payload_t worth of fields.
interface vec_alu_result_skid_if;
  import vec_pkg::*;

  logic                  valid;
  logic                  ready;
  lane_vec_t             result;
  logic [LANES-1:0]      cmp;
  logic [REG_ADDR_W-1:0] rd;
  logic                  we;

  modport master (output valid, result, cmp, rd, we, input ready);
  modport slave  (input valid, result, cmp, rd, we, output ready);

endinterface

// File: rtl/vec_result_reg.sv
// One writeback payload register with load enable; synchronous clear has priority over load.
module vec_result_reg
  import vec_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  vec_wb_payload_t d,
  output vec_wb_payload_t q
);

  vec_wb_payload_t payload_d;
  vec_wb_payload_t payload_q;

  // next payload: clear, load or hold
  always_comb begin
    payload_d = payload_q;
    if (clr) begin
      payload_d = '0;
    end else if (load) begin
      payload_d = d;
    end else begin
      payload_d = payload_q;
    end
  end

  // payload storage
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  assign q = payload_q;

endmodule

// File: rtl/vec_alu_result_skid.sv
// 2-entry skid buffer between ALUV and writeback; in_ready depends only on registered state.
// Optional backpressure counter enabled by defining VEC_SKID_STATS_EN.
module vec_alu_result_skid
  import vec_pkg::*;
`ifdef VEC_SKID_STATS_EN
#(
  parameter int STAT_W = 16
)
`endif
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
`ifdef VEC_SKID_STATS_EN
  output logic [STAT_W-1:0]           stall_count,
`endif
  vec_alu_result_skid_if.slave        in_if,
  vec_alu_result_skid_if.master       out_if
);

  skid_state_t     state_d, state_q;
  vec_wb_payload_t in_payload, main_in, main_q, skid_q;
  logic            in_ready, accept, drain;
  logic            main_load, main_from_skid, skid_load;

  assign in_ready   = (state_q != SKID_FULL) & ~rst;
  assign accept     = in_if.valid & in_ready;
  assign drain      = out_if.valid & out_if.ready;
  assign in_payload = '{result: in_if.result, cmp: in_if.cmp, rd: in_if.rd, we: in_if.we};
  assign main_in    = main_from_skid ? skid_q : in_payload;

  // next-state and register load controls; rst and flush win over any handshake
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (rst || flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            state_d   = SKID_ONE;
            main_load = 1'b1;
          end else begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_ONE: begin
          if (accept && !drain) begin
            state_d   = SKID_FULL;
            skid_load = 1'b1;
          end else if (!accept && drain) begin
            state_d = SKID_EMPTY;
          end else if (accept && drain) begin
            state_d   = SKID_ONE;
            main_load = 1'b1;
          end else begin
            state_d = SKID_ONE;
          end
        end
        SKID_FULL: begin
          if (drain) begin
            state_d        = SKID_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end else begin
            state_d = SKID_FULL;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
        end
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  vec_result_reg u_main (
    .clk  (clk),
    .clr  (rst),
    .load (main_load),
    .d    (main_in),
    .q    (main_q)
  );

  vec_result_reg u_skid (
    .clk  (clk),
    .clr  (rst),
    .load (skid_load),
    .d    (in_payload),
    .q    (skid_q)
  );

  // flush leaves stale data in MAIN, so the write enable is gated by valid
  assign in_if.ready   = in_ready;
  assign out_if.valid  = (state_q != SKID_EMPTY);
  assign out_if.result = main_q.result;
  assign out_if.cmp    = main_q.cmp;
  assign out_if.rd     = main_q.rd;
  assign out_if.we     = main_q.we & out_if.valid;

`ifdef VEC_SKID_STATS_EN
  logic [STAT_W-1:0] stall_count_d, stall_count_q;

  // saturating count of cycles where ALUV offered a beat that was refused
  always_comb begin
    stall_count_d = stall_count_q;
    if (in_if.valid && !in_ready && !rst && (stall_count_q != {STAT_W{1'b1}})) begin
      stall_count_d = stall_count_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // counter register, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_vec_alu_result_skid.sv
// Directed self-checking bench for vec_alu_result_skid; stall counter checks need VEC_SKID_STATS_EN.
module tb_vec_alu_result_skid;
  import vec_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_vec;
  int   n_err;

  vec_alu_result_skid_if in_if ();
  vec_alu_result_skid_if out_if ();

`ifdef VEC_SKID_STATS_EN
  logic [2:0] stall_count;
  vec_alu_result_skid #(.STAT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall_count (stall_count),
    .in_if       (in_if),
    .out_if      (out_if)
  );
`else
  vec_alu_result_skid dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in_if),
    .out_if (out_if)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic lane_vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                   input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    lane_vec_t v;
    v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3; v[4] = b4; v[5] = b5;
    return v;
  endfunction

  task automatic drive(input lane_vec_t r, input logic [5:0] c, input logic [3:0] d, input logic w);
    in_if.valid  = 1'b1;
    in_if.result = r;
    in_if.cmp    = c;
    in_if.rd     = d;
    in_if.we     = w;
  endtask

  task automatic expect_out(input string tag, input lane_vec_t r, input logic [5:0] c,
                            input logic [3:0] d, input logic w);
    check({tag, "_valid"}, 64'(out_if.valid), 64'd1);
    check({tag, "_result"}, 64'(out_if.result), 64'(r));
    check({tag, "_cmp"}, 64'(out_if.cmp), 64'(c));
    check({tag, "_rd"}, 64'(out_if.rd), 64'(d));
    check({tag, "_we"}, 64'(out_if.we), 64'(w));
  endtask

  initial begin
    lane_vec_t va, vb, vc;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_if.valid = 1'b0;
    in_if.result = '0;
    in_if.cmp = 6'd0;
    in_if.rd = 4'd0;
    in_if.we = 1'b0;
    out_if.ready = 1'b0;

    // reset held two cycles
    step();
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_in_ready", 64'(in_if.ready), 64'd0);
    step();
    check("rst_out_we", 64'(out_if.we), 64'd0);
    check("rst_out_result", 64'(out_if.result), 64'd0);
    check("rst_in_ready2", 64'(in_if.ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_if.ready), 64'd1);

    // single beat, 1-cycle latency
    out_if.ready = 1'b1;
    va = mk(8'd2, 8'd9, 8'd6, 8'd11, 8'd14, 8'd13);
    drive(va, 6'b000101, 4'd3, 1'b1);
    step();
    expect_out("t2_first", va, 6'b000101, 4'd3, 1'b1);
    check("t2_result_hex", 64'(out_if.result), 64'h0d0e0b060902);

    // four back-to-back beats, alternating write enable
    for (int i = 0; i < 4; i++) begin
      vb = mk(8'(16*i + 1), 8'(16*i + 2), 8'(16*i + 3), 8'(16*i + 4), 8'(16*i + 5), 8'(16*i + 6));
      drive(vb, 6'(i + 8), 4'(i + 5), i[0]);
      step();
      expect_out($sformatf("t2_b2b%0d", i), vb, 6'(i + 8), 4'(i + 5), i[0]);
      check($sformatf("t2_b2b%0d_in_ready", i), 64'(in_if.ready), 64'd1);
    end
    in_if.valid = 1'b0;
    step();
    check("t2_drained", 64'(out_if.valid), 64'd0);
    check("t2_drained_we", 64'(out_if.we), 64'd0);

    // fill both entries under backpressure, then drain in order
    out_if.ready = 1'b0;
    va = mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5);
    vb = mk(8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5);
    vc = mk(8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5);
    drive(va, 6'h0A, 4'hA, 1'b1);
    step();
    drive(vb, 6'h0B, 4'hB, 1'b1);
    step();
    check("t3_full_in_ready", 64'(in_if.ready), 64'd0);
    expect_out("t3_hold_a", va, 6'h0A, 4'hA, 1'b1);
    drive(vc, 6'h0C, 4'hC, 1'b0);
    step();
    expect_out("t3_stall_a", va, 6'h0A, 4'hA, 1'b1);
    out_if.ready = 1'b1;
    step();
    expect_out("t3_b", vb, 6'h0B, 4'hB, 1'b1);
    check("t3_in_ready_after", 64'(in_if.ready), 64'd1);
    step();
    expect_out("t3_c", vc, 6'h0C, 4'hC, 1'b0);
    in_if.valid = 1'b0;
    step();
    check("t3_empty", 64'(out_if.valid), 64'd0);

    // simultaneous accept and drain in ONE
    va = mk(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    vb = mk(8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC);
    drive(va, 6'h15, 4'h1, 1'b1);
    step();
    expect_out("t4_d", va, 6'h15, 4'h1, 1'b1);
    drive(vb, 6'h2A, 4'h2, 1'b1);
    step();
    expect_out("t4_e", vb, 6'h2A, 4'h2, 1'b1);
    check("t4_in_ready", 64'(in_if.ready), 64'd1);
    in_if.valid = 1'b0;
    step();
    check("t4_empty", 64'(out_if.valid), 64'd0);

    // flush while FULL with an input offered
    out_if.ready = 1'b0;
    drive(va, 6'h01, 4'h4, 1'b1);
    step();
    drive(vb, 6'h02, 4'h5, 1'b1);
    step();
    check("t5_full", 64'(in_if.ready), 64'd0);
    drive(vc, 6'h03, 4'h6, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_if.valid = 1'b0;
    check("t5_out_valid", 64'(out_if.valid), 64'd0);
    check("t5_out_we", 64'(out_if.we), 64'd0);
    check("t5_in_ready", 64'(in_if.ready), 64'd1);
    out_if.ready = 1'b1;
    step();
    check("t5_no_ghost", 64'(out_if.valid), 64'd0);
    step();
    check("t5_no_ghost2", 64'(out_if.valid), 64'd0);

`ifdef VEC_SKID_STATS_EN
    // saturating stall counter with STAT_W=3
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_cnt_rst", 64'(stall_count), 64'd0);
    out_if.ready = 1'b0;
    drive(va, 6'h01, 4'h1, 1'b1);
    step();
    drive(vb, 6'h02, 4'h2, 1'b1);
    step();
    check("t6_cnt_fill", 64'(stall_count), 64'd0);
    for (int i = 0; i < 5; i++) step();
    check("t6_cnt_5", 64'(stall_count), 64'd5);
    for (int i = 0; i < 5; i++) step();
    check("t6_cnt_sat", 64'(stall_count), 64'd7);
    in_if.valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_cnt_flush", 64'(stall_count), 64'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_cnt_clr", 64'(stall_count), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
